// File: rtl/clock_set_controller_if.sv
// Front-panel bundle between the board buttons / enable and the clock core's mode inputs.
// The controller takes the slave side; whoever drives the buttons takes the master side.
interface clock_set_controller_if;
  logic       i_en;
  logic       i_btn_minutes;
  logic       i_btn_hours;
  logic       i_btn_seconds;
  logic [1:0] o_mode;
  logic       o_fast_set;

  modport master (
    output i_en,
    output i_btn_minutes,
    output i_btn_hours,
    output i_btn_seconds,
    input  o_mode,
    input  o_fast_set
  );

  modport slave (
    input  i_en,
    input  i_btn_minutes,
    input  i_btn_hours,
    input  i_btn_seconds,
    output o_mode,
    output o_fast_set
  );
endinterface

// File: rtl/clock_set_controller.sv
// Time-set mode sequencer: synchronises and debounces three pushbuttons and drives the
// clock core's mode select and fast-set select, switching to fast rate after a long hold.
module clock_set_controller #(
  parameter int DEBOUNCE_CYCLES  = 1_000_000,
  parameter int FAST_HOLD_CYCLES = 100_000_000
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  clock_set_controller_if.slave  ctrl_if
);

  localparam int DB_W   = (DEBOUNCE_CYCLES  > 1) ? $clog2(DEBOUNCE_CYCLES)  : 1;
  localparam int HOLD_W = (FAST_HOLD_CYCLES > 1) ? $clog2(FAST_HOLD_CYCLES) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FAST_HOLD_CYCLES - 1);

  // Button bit order: [0] minutes, [1] hours, [2] seconds.
  localparam int BTN_MIN = 0;
  localparam int BTN_HRS = 1;
  localparam int BTN_SEC = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SET_MIN = 2'd1,
    SET_HRS = 2'd2,
    CLR_SEC = 2'd3
  } state_e;

  logic [2:0]            btn_raw;
  logic [2:0]            sync1_q;
  logic [2:0]            sync2_q;
  logic [2:0]            deb_q;
  logic [2:0]            deb_d;
  logic [2:0][DB_W-1:0]  db_cnt_q;
  logic [2:0][DB_W-1:0]  db_cnt_d;
  logic [2:0]            pressed_q;

  state_e                state_q;
  state_e                state_d;
  logic [HOLD_W-1:0]     hold_q;
  logic [HOLD_W-1:0]     hold_d;
  logic                  fast_q;
  logic                  fast_d;
  logic                  in_set_state;

  assign btn_raw = {ctrl_if.i_btn_seconds, ctrl_if.i_btn_hours, ctrl_if.i_btn_minutes};

  // Stage boundary: 2-flop synchronisers, debouncers and the registered pressed levels.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      db_cnt_q  <= '0;
      pressed_q <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      db_cnt_q  <= db_cnt_d;
      pressed_q <= deb_q;
    end
  end

  // A change is accepted only after DEBOUNCE_CYCLES consecutive mismatching cycles.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          deb_d[i]    = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Stage boundary: mode FSM state, hold counter and fast-set flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      fast_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      fast_q  <= fast_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = '0;
    fast_d       = 1'b0;
    in_set_state = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pressed_q[BTN_SEC])      state_d = CLR_SEC;
        else if (pressed_q[BTN_HRS]) state_d = SET_HRS;
        else if (pressed_q[BTN_MIN]) state_d = SET_MIN;
      end
      SET_MIN: if (!pressed_q[BTN_MIN]) state_d = IDLE;
      SET_HRS: if (!pressed_q[BTN_HRS]) state_d = IDLE;
      CLR_SEC: if (!pressed_q[BTN_SEC]) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (!ctrl_if.i_en) state_d = IDLE;

    // Counting only continues while staying in the same set state; any entry or exit clears it.
    in_set_state = (state_q == SET_MIN) || (state_q == SET_HRS);
    if (in_set_state && (state_d == state_q)) begin
      hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;
      fast_d = fast_q | (hold_q == HOLD_LAST);
    end
  end

  assign ctrl_if.o_mode     = state_q;
  assign ctrl_if.o_fast_set = fast_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with DEBOUNCE_CYCLES=4, FAST_HOLD_CYCLES=10.
module tb_clock_set_controller;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  clock_set_controller_if bus ();

  clock_set_controller #(
    .DEBOUNCE_CYCLES (4),
    .FAST_HOLD_CYCLES(10)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .ctrl_if(bus)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input logic m, input logic h, input logic s);
    bus.i_btn_minutes = m;
    bus.i_btn_hours   = h;
    bus.i_btn_seconds = s;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_en = 1'b1;
    set_btns(1'b1, 1'b1, 1'b1);
    tick();
    checks++;
    if (bus.o_mode !== 2'd0 || bus.o_fast_set !== 1'b0)
      $display("FAIL reset_state: mode=%0d fast=%0b, want mode=0 fast=0", bus.o_mode, bus.o_fast_set);
    else passed++;
    tick();
    checks++;
    if (bus.o_mode !== 2'd0 || bus.o_fast_set !== 1'b0)
      $display("FAIL reset_held: mode=%0d fast=%0b, want mode=0 fast=0", bus.o_mode, bus.o_fast_set);
    else passed++;
    rst = 1'b0;
    // First post-reset edge samples the buttons; mode appears 7 edges later.
    repeat (7) tick();
    checks++;
    if (bus.o_mode !== 2'd0)
      $display("FAIL reset_release_early: mode=%0d, want 0", bus.o_mode);
    else passed++;
    tick();
    checks++;
    if (bus.o_mode !== 2'd3 || bus.o_fast_set !== 1'b0)
      $display("FAIL reset_release_sec: mode=%0d fast=%0b, want mode=3 fast=0", bus.o_mode, bus.o_fast_set);
    else passed++;
    repeat (15) tick();
    checks++;
    if (bus.o_mode !== 2'd3 || bus.o_fast_set !== 1'b0)
      $display("FAIL clr_sec_no_fast: mode=%0d fast=%0b, want mode=3 fast=0", bus.o_mode, bus.o_fast_set);
    else passed++;
    set_btns(1'b0, 1'b0, 1'b0);
    repeat (7) tick();
    checks++;
    if (bus.o_mode !== 2'd3)
      $display("FAIL clr_sec_release_early: mode=%0d, want 3", bus.o_mode);
    else passed++;
    tick();
    checks++;
    if (bus.o_mode !== 2'd0)
      $display("FAIL clr_sec_release: mode=%0d, want 0", bus.o_mode);
    else passed++;
    repeat (4) tick();
  endtask

  task automatic test_minutes_press();
    set_btns(1'b1, 1'b0, 1'b0);
    repeat (7) tick();
    checks++;
    if (bus.o_mode !== 2'd0)
      $display("FAIL min_press_early: mode=%0d, want 0", bus.o_mode);
    else passed++;
    tick();
    checks++;
    if (bus.o_mode !== 2'd1 || bus.o_fast_set !== 1'b0)
      $display("FAIL min_press: mode=%0d fast=%0b, want mode=1 fast=0", bus.o_mode, bus.o_fast_set);
    else passed++;
    tick();
    set_btns(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++;
      if (bus.o_mode !== 2'd1 || bus.o_fast_set !== 1'b0)
        $display("FAIL min_short_hold t%0d: mode=%0d fast=%0b, want mode=1 fast=0", i, bus.o_mode, bus.o_fast_set);
      else passed++;
    end
    tick();
    checks++;
    if (bus.o_mode !== 2'd0 || bus.o_fast_set !== 1'b0)
      $display("FAIL min_release: mode=%0d fast=%0b, want mode=0 fast=0", bus.o_mode, bus.o_fast_set);
    else passed++;
    repeat (4) tick();
  endtask

  task automatic test_hours_hold();
    set_btns(1'b0, 1'b1, 1'b0);
    repeat (8) tick();
    checks++;
    if (bus.o_mode !== 2'd2 || bus.o_fast_set !== 1'b0)
      $display("FAIL hrs_press: mode=%0d fast=%0b, want mode=2 fast=0", bus.o_mode, bus.o_fast_set);
    else passed++;
    repeat (9) tick();
    checks++;
    if (bus.o_fast_set !== 1'b0)
      $display("FAIL hrs_fast_early: fast=%0b, want 0", bus.o_fast_set);
    else passed++;
    tick();
    checks++;
    if (bus.o_mode !== 2'd2 || bus.o_fast_set !== 1'b1)
      $display("FAIL hrs_fast_rise: mode=%0d fast=%0b, want mode=2 fast=1", bus.o_mode, bus.o_fast_set);
    else passed++;
    repeat (4) tick();
    checks++;
    if (bus.o_mode !== 2'd2 || bus.o_fast_set !== 1'b1)
      $display("FAIL hrs_fast_stays: mode=%0d fast=%0b, want mode=2 fast=1", bus.o_mode, bus.o_fast_set);
    else passed++;
    set_btns(1'b0, 1'b0, 1'b0);
    repeat (7) tick();
    checks++;
    if (bus.o_mode !== 2'd2 || bus.o_fast_set !== 1'b1)
      $display("FAIL hrs_release_early: mode=%0d fast=%0b, want mode=2 fast=1", bus.o_mode, bus.o_fast_set);
    else passed++;
    tick();
    checks++;
    if (bus.o_mode !== 2'd0 || bus.o_fast_set !== 1'b0)
      $display("FAIL hrs_release: mode=%0d fast=%0b, want mode=0 fast=0", bus.o_mode, bus.o_fast_set);
    else passed++;
    repeat (4) tick();
  endtask

  task automatic test_bounce();
    logic [7:0] pattern;
    pattern = 8'b0111_0111;  // applied LSB first: high 3, low 1, high 3, low
    for (int i = 0; i < 20; i++) begin
      bus.i_btn_minutes = (i < 8) ? pattern[i] : 1'b0;
      tick();
      checks++;
      if (bus.o_mode !== 2'd0)
        $display("FAIL bounce t%0d: mode=%0d, want 0", i, bus.o_mode);
      else passed++;
    end
  endtask

  task automatic test_no_preempt();
    set_btns(1'b1, 1'b0, 1'b0);
    repeat (8) tick();
    checks++;
    if (bus.o_mode !== 2'd1)
      $display("FAIL preempt_min_enter: mode=%0d, want 1", bus.o_mode);
    else passed++;
    set_btns(1'b1, 1'b1, 1'b0);
    repeat (12) tick();
    checks++;
    if (bus.o_mode !== 2'd1 || bus.o_fast_set !== 1'b1)
      $display("FAIL preempt_ignored: mode=%0d fast=%0b, want mode=1 fast=1", bus.o_mode, bus.o_fast_set);
    else passed++;
    set_btns(1'b0, 1'b1, 1'b0);
    repeat (7) tick();
    checks++;
    if (bus.o_mode !== 2'd1)
      $display("FAIL preempt_release_early: mode=%0d, want 1", bus.o_mode);
    else passed++;
    tick();
    checks++;
    if (bus.o_mode !== 2'd0 || bus.o_fast_set !== 1'b0)
      $display("FAIL preempt_idle_gap: mode=%0d fast=%0b, want mode=0 fast=0", bus.o_mode, bus.o_fast_set);
    else passed++;
    tick();
    checks++;
    if (bus.o_mode !== 2'd2 || bus.o_fast_set !== 1'b0)
      $display("FAIL preempt_take_hrs: mode=%0d fast=%0b, want mode=2 fast=0", bus.o_mode, bus.o_fast_set);
    else passed++;
    repeat (9) tick();
    checks++;
    if (bus.o_fast_set !== 1'b0)
      $display("FAIL preempt_fast_restart: fast=%0b, want 0", bus.o_fast_set);
    else passed++;
    tick();
    checks++;
    if (bus.o_fast_set !== 1'b1)
      $display("FAIL preempt_fast_rise: fast=%0b, want 1", bus.o_fast_set);
    else passed++;
  endtask

  task automatic test_enable();
    bus.i_en = 1'b0;
    tick();
    checks++;
    if (bus.o_mode !== 2'd0 || bus.o_fast_set !== 1'b0)
      $display("FAIL en_drop: mode=%0d fast=%0b, want mode=0 fast=0", bus.o_mode, bus.o_fast_set);
    else passed++;
    repeat (3) tick();
    checks++;
    if (bus.o_mode !== 2'd0)
      $display("FAIL en_low_idle: mode=%0d, want 0", bus.o_mode);
    else passed++;
    bus.i_en = 1'b1;
    tick();
    checks++;
    if (bus.o_mode !== 2'd2 || bus.o_fast_set !== 1'b0)
      $display("FAIL en_raise: mode=%0d fast=%0b, want mode=2 fast=0", bus.o_mode, bus.o_fast_set);
    else passed++;
    repeat (9) tick();
    checks++;
    if (bus.o_fast_set !== 1'b0)
      $display("FAIL en_fast_early: fast=%0b, want 0", bus.o_fast_set);
    else passed++;
    tick();
    checks++;
    if (bus.o_fast_set !== 1'b1)
      $display("FAIL en_fast_rise: fast=%0b, want 1", bus.o_fast_set);
    else passed++;
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    tick();
    checks++;
    if (bus.o_mode !== 2'd0 || bus.o_fast_set !== 1'b0)
      $display("FAIL mid_reset: mode=%0d fast=%0b, want mode=0 fast=0", bus.o_mode, bus.o_fast_set);
    else passed++;
    set_btns(1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    checks++;
    if (bus.o_mode !== 2'd0 || bus.o_fast_set !== 1'b0)
      $display("FAIL mid_reset_after: mode=%0d fast=%0b, want mode=0 fast=0", bus.o_mode, bus.o_fast_set);
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    bus.i_en = 1'b0;
    set_btns(1'b0, 1'b0, 1'b0);
    test_reset();
    test_minutes_press();
    test_hours_hold();
    test_bounce();
    test_no_preempt();
    test_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
